// File: rtl/sw_input_conditioner.sv
// Board switch conditioner: 2-FF sync, per-bit debounce, edge pulses and button auto-repeat.
// Bit order of the internal vector: [4:0] = {DOWN,RIGHT,MID,LEFT,UP}, [20:5] = DIP_SW.
module sw_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned CNT_W           = 26
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [15:0] DIP_SW,
    input  logic        PUSH_SW_UP,
    input  logic        PUSH_SW_LEFT,
    input  logic        PUSH_SW_MID,
    input  logic        PUSH_SW_RIGHT,
    input  logic        PUSH_SW_DOWN,
    output logic [4:0]  btn_level,
    output logic [4:0]  btn_press,
    output logic [4:0]  btn_release,
    output logic [15:0] dip_val,
    output logic        dip_chg
);

    localparam int unsigned NB  = 5;
    localparam int unsigned NIN = NB + 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [NIN-1:0]            raw;
    logic [NIN-1:0]            sync_meta_q;
    logic [NIN-1:0]            sync_q;
    logic [NIN-1:0]            stable_q;
    logic [NIN-1:0][CNT_W-1:0] db_cnt_q;
    logic [NIN-1:0]            accept_c;

    logic [NB-1:0]             rise_c;
    logic [NB-1:0]             fall_c;
    logic [NB-1:0][1:0]        state_q;
    logic [NB-1:0][1:0]        state_d;
    logic [NB-1:0][CNT_W-1:0]  rep_cnt_q;
    logic [NB-1:0][CNT_W-1:0]  rep_cnt_d;
    logic [NB-1:0]             rep_pulse_c;

    assign raw = {DIP_SW, PUSH_SW_DOWN, PUSH_SW_RIGHT, PUSH_SW_MID, PUSH_SW_LEFT, PUSH_SW_UP};

    // A bit is accepted on the edge where its mismatch has persisted DEBOUNCE_CYCLES cycles.
    always_comb begin
        accept_c = '0;
        for (int i = 0; i < NIN; i++) begin
            accept_c[i] = (sync_q[i] != stable_q[i]) && (db_cnt_q[i] == DB_LAST);
        end
    end

    assign rise_c = accept_c[NB-1:0] & sync_q[NB-1:0];
    assign fall_c = accept_c[NB-1:0] & ~sync_q[NB-1:0];

    // Synchronisers, debounce counters and accepted levels.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            stable_q    <= '0;
            db_cnt_q    <= '0;
        end else begin
            sync_meta_q <= raw;
            sync_q      <= sync_meta_q;
            stable_q    <= stable_q ^ accept_c;
            for (int i = 0; i < NIN; i++) begin
                if ((sync_q[i] == stable_q[i]) || accept_c[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] != CNT_MAX) begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Auto-repeat next-state logic; a release always overrides a due repeat.
    always_comb begin
        state_d     = state_q;
        rep_cnt_d   = rep_cnt_q;
        rep_pulse_c = '0;
        for (int i = 0; i < NB; i++) begin
            if (rep_cnt_q[i] != CNT_MAX) begin
                rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
            case (state_q[i])
                ST_IDLE: begin
                    rep_cnt_d[i] = '0;
                    if (rise_c[i]) begin
                        state_d[i] = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (fall_c[i]) begin
                        state_d[i]   = ST_IDLE;
                        rep_cnt_d[i] = '0;
                    end else if (REPEAT_EN && (rep_cnt_q[i] == HOLD_LAST)) begin
                        state_d[i]     = ST_REPEAT;
                        rep_cnt_d[i]   = '0;
                        rep_pulse_c[i] = 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (fall_c[i]) begin
                        state_d[i]   = ST_IDLE;
                        rep_cnt_d[i] = '0;
                    end else if (rep_cnt_q[i] == REP_LAST) begin
                        rep_cnt_d[i]   = '0;
                        rep_pulse_c[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i]   = ST_IDLE;
                    rep_cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q   <= {NB{ST_IDLE}};
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Registered pulse outputs, aligned with the edge where the level updates.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            btn_press   <= '0;
            btn_release <= '0;
            dip_chg     <= 1'b0;
        end else begin
            btn_press   <= rise_c | rep_pulse_c;
            btn_release <= fall_c;
            dip_chg     <= |accept_c[NIN-1:NB];
        end
    end

    assign btn_level = stable_q[NB-1:0];
    assign dip_val   = stable_q[NIN-1:NB];

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with short debounce/hold/repeat timings.
module tb_sw_input_conditioner;

    logic        clk = 1'b0;
    logic        rstb;
    logic [15:0] dip_sw;
    logic        up, left, mid, right, down;
    logic [4:0]  btn_level, btn_press, btn_release;
    logic [15:0] dip_val;
    logic        dip_chg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .REPEAT_EN      (1'b1),
        .CNT_W          (26)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .DIP_SW       (dip_sw),
        .PUSH_SW_UP   (up),
        .PUSH_SW_LEFT (left),
        .PUSH_SW_MID  (mid),
        .PUSH_SW_RIGHT(right),
        .PUSH_SW_DOWN (down),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .dip_val      (dip_val),
        .dip_chg      (dip_chg)
    );

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rstb = 1'b1; dip_sw = 16'h0000;
        up = 0; left = 0; mid = 0; right = 0; down = 0;
        step(2);
        rstb = 1'b0;
        step(3);
        checks++;
        if ({btn_level, btn_press, btn_release, dip_val, dip_chg} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {btn_level, btn_press, btn_release, dip_val, dip_chg});
        end
    endtask

    task automatic test_press_release;
        logic [4:0] exp_press, exp_rel;
        logic       exp_lvl;
        up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_press = (k == 6) ? 5'b00001 : 5'b00000;
            exp_lvl   = (k >= 6);
            checks++;
            if (btn_press !== exp_press || btn_level[0] !== exp_lvl) begin
                errors++;
                $display("FAIL up_press k=%0d got press=%b lvl=%b required press=%b lvl=%b",
                         k, btn_press, btn_level[0], exp_press, exp_lvl);
            end
        end
        up = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_rel   = (k == 6) ? 5'b00001 : 5'b00000;
            exp_lvl   = (k < 6);
            checks++;
            if (btn_release !== exp_rel || btn_level[0] !== exp_lvl || btn_press !== 5'b0) begin
                errors++;
                $display("FAIL up_release k=%0d got rel=%b lvl=%b press=%b required rel=%b lvl=%b press=0",
                         k, btn_release, btn_level[0], btn_press, exp_rel, exp_lvl);
            end
        end
    endtask

    task automatic test_bounce;
        logic [4:0] exp_press;
        for (int b = 0; b < 4; b++) begin
            mid = (b % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                step(1);
                checks++;
                if (btn_press !== 5'b0 || btn_level !== 5'b0) begin
                    errors++;
                    $display("FAIL mid_bounce b=%0d got press=%b lvl=%b required 0", b, btn_press, btn_level);
                end
            end
        end
        mid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            exp_press = (k == 6) ? 5'b00100 : 5'b00000;
            checks++;
            if (btn_press !== exp_press || btn_level[2] !== (k >= 6)) begin
                errors++;
                $display("FAIL mid_settle k=%0d got press=%b lvl=%b required press=%b",
                         k, btn_press, btn_level[2], exp_press);
            end
        end
        mid = 1'b0;
        step(10);
    endtask

    task automatic test_auto_repeat;
        logic [4:0] exp_press, exp_rel;
        down = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            step(1);
            if (k == 60) down = 1'b0;
            exp_press = (k == 6 || k == 26 || k == 34 || k == 42 || k == 50 || k == 58)
                        ? 5'b10000 : 5'b00000;
            exp_rel   = (k == 66) ? 5'b10000 : 5'b00000;
            checks++;
            if (btn_press !== exp_press || btn_release !== exp_rel) begin
                errors++;
                $display("FAIL down_repeat k=%0d got press=%b rel=%b required press=%b rel=%b",
                         k, btn_press, btn_release, exp_press, exp_rel);
            end
        end
    endtask

    task automatic test_dip;
        logic [15:0] exp_val;
        dip_sw = 16'hA5A5;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_val = (k >= 6) ? 16'hA5A5 : 16'h0000;
            checks++;
            if (dip_val !== exp_val || dip_chg !== (k == 6)) begin
                errors++;
                $display("FAIL dip_update k=%0d got val=%h chg=%b required val=%h chg=%b",
                         k, dip_val, dip_chg, exp_val, (k == 6));
            end
        end
        dip_sw = 16'hFFFF;
        step(3);
        dip_sw = 16'hA5A5;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checks++;
            if (dip_val !== 16'hA5A5 || dip_chg !== 1'b0) begin
                errors++;
                $display("FAIL dip_glitch k=%0d got val=%h chg=%b required val=a5a5 chg=0",
                         k, dip_val, dip_chg);
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        logic [4:0] exp_press;
        left = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            exp_press = (k == 6 || k == 26) ? 5'b00010 : 5'b00000;
            checks++;
            if (btn_press !== exp_press) begin
                errors++;
                $display("FAIL left_pre_reset k=%0d got %b required %b", k, btn_press, exp_press);
            end
        end
        rstb = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, dip_val, dip_chg} !== 32'h0) begin
            errors++;
            $display("FAIL reset_async got %h required 0",
                     {btn_level, btn_press, btn_release, dip_val, dip_chg});
        end
        step(1);
        rstb = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            exp_press = (k == 6 || k == 26) ? 5'b00010 : 5'b00000;
            checks++;
            if (btn_press !== exp_press || dip_chg !== (k == 6) || btn_level[1] !== (k >= 6)) begin
                errors++;
                $display("FAIL left_post_reset k=%0d got press=%b chg=%b lvl=%b required press=%b chg=%b",
                         k, btn_press, dip_chg, btn_level[1], exp_press, (k == 6));
            end
        end
        checks++;
        if (dip_val !== 16'hA5A5) begin
            errors++;
            $display("FAIL dip_after_reset got %h required a5a5", dip_val);
        end
        left = 1'b0;
        step(12);
        checks++;
        if (btn_level !== 5'b0) begin
            errors++;
            $display("FAIL left_released got %b required 0", btn_level);
        end
    endtask

    task automatic test_simultaneous;
        logic [4:0] exp_press, exp_rel;
        right = 1'b1;
        step(8);
        checks++;
        if (btn_level !== 5'b01000) begin
            errors++;
            $display("FAIL right_level got %b required 01000", btn_level);
        end
        right = 1'b0;
        left  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_press = (k == 6) ? 5'b00010 : 5'b00000;
            exp_rel   = (k == 6) ? 5'b01000 : 5'b00000;
            checks++;
            if (btn_press !== exp_press || btn_release !== exp_rel) begin
                errors++;
                $display("FAIL same_edge k=%0d got press=%b rel=%b required press=%b rel=%b",
                         k, btn_press, btn_release, exp_press, exp_rel);
            end
        end
        checks++;
        if (btn_level !== 5'b00010) begin
            errors++;
            $display("FAIL same_edge_level got %b required 00010", btn_level);
        end
    endtask

    initial begin
        test_reset;
        test_press_release;
        test_bounce;
        test_auto_repeat;
        test_dip;
        test_reset_mid_hold;
        test_simultaneous;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
